pipeline_mem_arbiter: RTL and testbench
=======================================

Name: pipeline_mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port (read-only) and its data (load/store) port.
- Sits between the fetch/memory stages of Pipeline_Top and the memory model.
- Arbitrates with data-port priority and an instruction-starvation guard.
- Sequences variable-latency memory transfers and gates all new grants on the top-level start signal.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width; byte-strobe width is DATA_W/8.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before IF is forced; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  enables new grants; level-sensitive.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetch data; valid in the if_ready cycle, held afterwards.
- if_ready  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data; valid in the d_ready cycle, held afterwards.
- d_ready  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered write data.
- mem_wstrb  out  DATA_W/8  registered byte enables; forced to 0 on reads.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready is high.
- mem_ready  in  1  memory completion; may be high in the first mem_req cycle (zero wait).
- busy  out  1  high in IF_XFER or D_XFER.

Behaviour:
- Reset values (rst low, asynchronous):
  - State = IDLE; starve_cnt = 0.
  - mem_req, mem_we, mem_wstrb, if_ready, d_ready, busy = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- A reset mid-transfer aborts the transfer: mem_req drops immediately; no ready pulse is issued.
- States: IDLE, IF_XFER, D_XFER.
- IDLE:
  - If start=1, pick one eligible requester and register mem_addr/mem_we/mem_wdata/mem_wstrb.
  - IF grant sets mem_we=0 and mem_wstrb=0.
  - Next state is IF_XFER or D_XFER; otherwise stay in IDLE.
- Eligibility: a requester whose ready pulse is high in the current cycle is not eligible. This prevents re-granting a stale request.
- Priority:
  - Data wins, unless starve_cnt == STARVE_MAX and if_req=1; then IF wins.
  - A lone requester always wins.
- starve_cnt:
  - Increments on each data grant while if_req=1.
  - Clears on an IF grant, or in any cycle where if_req=0.
  - Saturates at STARVE_MAX.
- XFER states:
  - mem_req stays high and memory outputs stay constant until mem_ready=1.
  - On mem_ready: capture mem_rdata into if_rdata (IF) or d_rdata (data) and pulse the matching ready on the next cycle; return to IDLE.
  - Stores still pulse d_ready; d_rdata is unchanged on stores.
- Latency and throughput:
  - Minimum latency is 2 cycles: grant in cycle 0, mem_req in cycle 1 with mem_ready=1, ready in cycle 2.
  - Peak throughput is one transfer per 2 cycles.
  - The ready-pulse cycle is also an IDLE arbitration cycle for the other requester.
- start:
  - start=0 blocks new grants only; an in-flight transfer completes and pulses ready normally.
  - Deasserting start mid-transfer has no effect on that transfer.
- Requests dropped before their ready pulse violate protocol. The arbiter ignores such a request at the next arbitration; a transfer already issued still completes.
- if_ready and d_ready are never high in the same cycle; busy and mem_req are identical.

Test Plan:
- Reset/start gating: rst low, then high; start=0 with if_req=1 at addr 0x0 for 5 cycles → mem_req stays 0. Raise start → mem_req=1 with mem_addr=0x0 one cycle later; mem_ready=1 with mem_rdata=0x00500093 → if_ready pulses next cycle with if_rdata=0x00500093.
- Contention: if_req and d_req (load 0x100) asserted together, zero-wait memory returning 0xDEADBEEF → data is served first (d_ready and d_rdata=0xDEADBEEF at cycle 2), IF served next (if_ready at cycle 4).
- Starvation: STARVE_MAX=4, if_req held high, d_req re-asserted after each d_ready → exactly 4 data grants, then an IF grant, then starve_cnt=0.
- Store with wait states: d_we=1, d_addr=0x20, d_wdata=0x12345678, d_wstrb=4'b0011, mem_ready delayed 3 cycles → mem outputs constant for 3 cycles, then d_ready pulses once; d_rdata unchanged.
- Reset mid-transfer: pull rst low during D_XFER → mem_req=0 and busy=0 immediately, no d_ready. After release with start=1 and d_req still high → re-granted cleanly.
- start dropped mid-transfer: deassert start during IF_XFER → transfer completes with if_ready; a pending d_req is not granted until start returns high.

Source files
------------

// File: rtl/pipeline_mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data ports.
// Data has priority; a starvation counter forces a fetch grant.
module pipeline_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IF_XFER = 2'd1;
    localparam logic [1:0] D_XFER  = 2'd2;
    localparam logic [3:0] SMAX    = 4'(STARVE_MAX);

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic       if_elig;
    logic       d_elig;
    logic       force_if;
    logic       grant_if;
    logic       grant_d;

    // A requester whose ready pulse is high is finishing, not asking again.
    always_comb begin
        if_elig  = if_req & ~if_ready;
        d_elig   = d_req & ~d_ready;
        force_if = if_elig && (starve_cnt == SMAX);
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (start && state == IDLE) begin
            grant_d  = d_elig && !force_if;
            grant_if = if_elig && !grant_d;
        end
    end

    assign mem_req = (state != IDLE);
    assign busy    = mem_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!if_req || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && starve_cnt < SMAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_addr  <= d_addr;
                        mem_we    <= d_we;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_we ? d_wstrb : '0;
                        state     <= D_XFER;
                    end else if (grant_if) begin
                        mem_addr  <= if_addr;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        state     <= IF_XFER;
                    end
                end
                IF_XFER: begin
                    if (mem_ready) begin
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                D_XFER: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        d_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Scoreboard bench for pipeline_mem_arbiter with a variable-latency
// memory model; read data is checked as ready pulses arrive.
module tb_pipeline_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] if_q[$];
    logic [31:0] d_q[$];

    logic [31:0] mem [0:255];
    int          lat = 0;
    int          wcnt = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    always #5 clk = ~clk;

    pipeline_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_rdata(if_rdata),
        .if_ready(if_ready),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_wstrb(d_wstrb),
        .d_rdata(d_rdata),
        .d_ready(d_ready),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy(busy)
    );

    assign mem_ready = mem_req && (wcnt == lat);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!mem_req || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (mem_req && mem_ready && mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
            wr_strb <= mem_wstrb;
        end
    end

    logic [31:0] mon_exp;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if (busy !== mem_req) begin
                errors++;
                $display("FAIL busy_eq_req busy=%b mem_req=%b", busy, mem_req);
            end
            checks++;
            if (if_ready && d_ready) begin
                errors++;
                $display("FAIL both_ready got 1/1 want not both");
            end
            if (if_ready) begin
                checks++;
                if (if_q.size() == 0) begin
                    errors++;
                    $display("FAIL if_spurious if_ready=1 want no pulse");
                end else begin
                    mon_exp = if_q.pop_front();
                    if (if_rdata !== mon_exp) begin
                        errors++;
                        $display("FAIL if_rdata got %h want %h", if_rdata, mon_exp);
                    end
                end
            end
            if (d_ready) begin
                checks++;
                if (d_q.size() == 0) begin
                    errors++;
                    $display("FAIL d_spurious d_ready=1 want no pulse");
                end else begin
                    mon_exp = d_q.pop_front();
                    if (d_rdata !== mon_exp) begin
                        errors++;
                        $display("FAIL d_rdata got %h want %h", d_rdata, mon_exp);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit dport, output int n);
        n = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dport ? d_ready : if_ready) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; d_wstrb = '0;
        repeat (3) step();
        checks++;
        if ({mem_req, mem_we, busy, if_ready, d_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {mem_req, mem_we, busy, if_ready, d_ready});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset_mem got %h/%h/%h want 0", mem_addr, mem_wdata, mem_wstrb);
        end
        checks++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h want 0", if_rdata, d_rdata);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_start_gating();
        lat = 0;
        if_req = 1'b1; if_addr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL gate_no_grant cyc %0d mem_req=%b want 0", i, mem_req);
            end
        end
        if_q.push_back(32'h00500093);
        start = 1'b1;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL gate_grant got req=%b addr=%h strb=%h want 1/0/0",
                     mem_req, mem_addr, mem_wstrb);
        end
        step();
        checks++;
        if (if_ready !== 1'b1) begin
            errors++;
            $display("FAIL gate_if_ready got %b want 1", if_ready);
        end
        if_req = 1'b0;
    endtask

    task automatic test_contention();
        lat = 0;
        if_req = 1'b1; if_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        d_q.push_back(32'hDEADBEEF);
        if_q.push_back(32'h11111111);
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL cont_d_first got req=%b addr=%h we=%b want 1/100/0",
                     mem_req, mem_addr, mem_we);
        end
        step();
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL cont_d_ready got %b/%h want 1/deadbeef", d_ready, d_rdata);
        end
        d_req = 1'b0;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            errors++;
            $display("FAIL cont_if_next got req=%b addr=%h want 1/4", mem_req, mem_addr);
        end
        step();
        checks++;
        if (if_ready !== 1'b1 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL cont_if_ready got %b/%b want 1/0", if_ready, d_ready);
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        int order[$];
        int exp_ord[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        lat = 0;
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        d_q.push_back(32'hCAFEF00D);
        if_q.push_back(32'h22222222);
        for (int c = 0; c < 200; c++) begin
            step();
            start = 1'b1;
            if (d_ready) begin
                order.push_back(0);
                d_q.push_back(32'hCAFEF00D);
                // hide the fetch-only window so data competes again
                start = 1'b0;
            end
            if (if_ready) begin
                order.push_back(1);
                if (order.size() >= 10) begin
                    if_req = 1'b0;
                    d_req = 1'b0;
                    break;
                end
                if_q.push_back(32'h22222222);
            end
        end
        void'(d_q.pop_back());
        checks++;
        if (order.size() != 10) begin
            errors++;
            $display("FAIL starve_count got %0d want 10", order.size());
        end
        for (int i = 0; i < 10 && i < order.size(); i++) begin
            checks++;
            if (order[i] != exp_ord[i]) begin
                errors++;
                $display("FAIL starve_order idx %0d got %0d want %0d", i, order[i], exp_ord[i]);
            end
        end
        step();
    endtask

    task automatic test_store_wait();
        int n;
        int wr0;
        lat = 3;
        wr0 = wr_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20;
        d_wdata = 32'h12345678; d_wstrb = 4'b0011;
        d_q.push_back(32'hCAFEF00D);
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 ||
                mem_wdata !== 32'h12345678 || mem_wstrb !== 4'b0011) begin
                errors++;
                $display("FAIL store_hold cyc %0d got %b/%b/%h/%h/%h", i,
                         mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
            end
            checks++;
            if (mem_ready !== (i == 3)) begin
                errors++;
                $display("FAIL store_wait cyc %0d mem_ready=%b want %b", i, mem_ready, i == 3);
            end
            if (i < 3) begin
                step();
                checks++;
                if (d_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL store_early cyc %0d d_ready=%b want 0", i, d_ready);
                end
            end
        end
        wait_ready(1'b1, n);
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL store_ready got %0d want 0", n);
        end
        d_req = 1'b0; d_we = 1'b0;
        checks++;
        if (wr_cnt != wr0 + 1 || wr_addr !== 32'h20 || wr_data !== 32'h12345678 ||
            wr_strb !== 4'b0011) begin
            errors++;
            $display("FAIL store_write got n=%0d %h/%h/%h want 1/20/12345678/3",
                     wr_cnt - wr0, wr_addr, wr_data, wr_strb);
        end
        step();
        checks++;
        if (d_ready !== 1'b0) begin
            errors++;
            $display("FAIL store_once d_ready=%b want 0", d_ready);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        lat = 5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        step();
        step();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rmid_inflight mem_req=%b want 1", mem_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_drop got %b/%b want 0/0", mem_req, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (d_ready !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL rmid_quiet cyc %0d got %b/%b want 0/0", i, d_ready, mem_req);
            end
        end
        lat = 0;
        d_q.push_back(32'hCAFEF00D);
        rst = 1'b1;
        wait_ready(1'b1, n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL rmid_regrant got %0d want 1", n);
        end
        d_req = 1'b0;
        step();
    endtask

    task automatic test_start_drop();
        int n;
        lat = 2;
        if_req = 1'b1; if_addr = 32'h4;
        if_q.push_back(32'h11111111);
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            errors++;
            $display("FAIL sdrop_grant got %b/%h want 1/4", mem_req, mem_addr);
        end
        start = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        wait_ready(1'b0, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL sdrop_if_done got %0d want 2", n);
        end
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL sdrop_blocked cyc %0d mem_req=%b want 0", i, mem_req);
            end
        end
        d_q.push_back(32'hDEADBEEF);
        start = 1'b1;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL sdrop_d_grant got %b/%h want 1/100", mem_req, mem_addr);
        end
        wait_ready(1'b1, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL sdrop_d_done got %0d want 2", n);
        end
        d_req = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]  = 32'h00500093;
        mem[1]  = 32'h11111111;
        mem[2]  = 32'h22222222;
        mem[8]  = 32'hAAAAAAAA;
        mem[16] = 32'hCAFEF00D;
        mem[64] = 32'hDEADBEEF;
        test_reset();
        test_start_gating();
        test_contention();
        test_starvation();
        test_store_wait();
        test_reset_mid();
        test_start_drop();
        repeat (2) step();
        checks++;
        if (if_q.size() != 0 || d_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got if=%0d d=%0d want 0/0", if_q.size(), d_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
